// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm unit: time-word field offsets, FSM encoding
// and day length in minutes.
package alarm_pkg;

  localparam int H1_LSB = 18;
  localparam int H0_LSB = 14;
  localparam int M1_LSB = 11;
  localparam int M0_LSB = 7;
  localparam int S1_LSB = 4;
  localparam int S0_LSB = 0;

  localparam int MINUTES_PER_DAY = 1440;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } alarm_state_t;

endpackage

// File: rtl/alarm_unit_time_to_minutes.sv
// Combinational conversion of a packed-BCD time word plus PM flag into an
// 11-bit minute-of-day (0..1439).
module time_to_minutes
  import alarm_pkg::*;
(
  input  logic [19:0] hh_mm_ss,
  input  logic        am_pm,
  input  logic        mode12h,
  output logic [10:0] minute_of_day
);

  logic [10:0] h1, h0, m1, m0;
  logic [10:0] hour24;

  always_comb begin
    h1 = {9'd0, hh_mm_ss[H1_LSB +: 2]};
    h0 = {7'd0, hh_mm_ss[H0_LSB +: 4]};
    m1 = {8'd0, hh_mm_ss[M1_LSB +: 3]};
    m0 = {7'd0, hh_mm_ss[M0_LSB +: 4]};
    // 12h display form counts twelve o'clock as 0, so PM is a plain +12
    hour24 = h1 * 11'd10 + h0 + ((mode12h & am_pm) ? 11'd12 : 11'd0);
    minute_of_day = hour24 * 11'd60 + m1 * 11'd10 + m0;
  end

endmodule

// File: rtl/alarm_unit.sv
// Four-slot alarm comparator with ringing/snooze state machine and debounced-free
// (synchronised, edge-detected) stop/snooze buttons.
module alarm_unit
  import alarm_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sec_tick,
  input  logic [19:0] hh_mm_ss,
  input  logic        am_pm,
  input  logic        mode12h,
  input  logic        set_time,
  input  logic        alarm_wr,
  input  logic [1:0]  alarm_id,
  input  logic [19:0] alarm_time,
  input  logic        alarm_am_pm,
  input  logic        alarm_en_in,
  input  logic        btn_stop,
  input  logic        btn_snooze,
  output logic        ring,
  output logic        buzzer,
  output logic [1:0]  active_id,
  output logic [1:0]  snooze_cnt,
  output logic [3:0]  alarm_armed
);

  localparam logic [8:0] RING_LAST   = 9'(RING_SECS - 1);
  localparam logic [8:0] SNOOZE_LAST = 9'(SNOOZE_SECS - 1);
  localparam logic [1:0] SNOOZE_MAX  = 2'(MAX_SNOOZE);

  alarm_state_t state, state_d;
  logic [10:0]  slot [4];
  logic [3:0]   en;
  logic [10:0]  cur_min, wr_min;
  logic [8:0]   sec_cnt;
  logic         phase;

  logic [1:0] stop_sync, snz_sync;
  logic       stop_prev, snz_prev, stop_p, snz_p;

  logic [3:0] match_vec;
  logic       match;
  logic [1:0] winner;
  logic       start_event, start_snooze, restart_ring;

  time_to_minutes u_cur (
    .hh_mm_ss     (hh_mm_ss),
    .am_pm        (am_pm),
    .mode12h      (mode12h),
    .minute_of_day(cur_min)
  );

  time_to_minutes u_wr (
    .hh_mm_ss     (alarm_time),
    .am_pm        (alarm_am_pm),
    .mode12h      (mode12h),
    .minute_of_day(wr_min)
  );

  always_comb begin
    winner = 2'd0;
    for (int i = 0; i < 4; i++) match_vec[i] = en[i] && (slot[i] == cur_min);
    for (int i = 3; i >= 0; i--) if (match_vec[i]) winner = 2'(i);
    match = sec_tick && !set_time && (hh_mm_ss[6:0] == 7'd0) && (|match_vec);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) slot[i] <= 11'd0;
      en <= 4'd0;
    end else if (alarm_wr) begin
      slot[alarm_id] <= wr_min;
      en[alarm_id]   <= alarm_en_in;
    end
  end

  // 2-FF synchroniser, then a registered rising-edge pulse (3 clk from the edge)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stop_sync <= 2'd0;
      snz_sync  <= 2'd0;
      stop_prev <= 1'b0;
      snz_prev  <= 1'b0;
      stop_p    <= 1'b0;
      snz_p     <= 1'b0;
    end else begin
      stop_sync <= {stop_sync[0], btn_stop};
      snz_sync  <= {snz_sync[0], btn_snooze};
      stop_prev <= stop_sync[1];
      snz_prev  <= snz_sync[1];
      stop_p    <= stop_sync[1] & ~stop_prev;
      snz_p     <= snz_sync[1] & ~snz_prev;
    end
  end

  always_comb begin
    state_d      = state;
    start_event  = 1'b0;
    start_snooze = 1'b0;
    restart_ring = 1'b0;
    case (state)
      ST_IDLE: begin
        if (match) begin
          state_d     = ST_RINGING;
          start_event = 1'b1;
        end
      end
      ST_RINGING: begin
        if (stop_p) begin
          state_d = ST_IDLE;
        end else if (snz_p && (snooze_cnt < SNOOZE_MAX)) begin
          state_d      = ST_SNOOZE;
          start_snooze = 1'b1;
        end else if (sec_tick && (sec_cnt == RING_LAST)) begin
          state_d = ST_IDLE;
        end
      end
      ST_SNOOZE: begin
        if (stop_p) begin
          state_d = ST_IDLE;
        end else if (sec_tick && (sec_cnt == SNOOZE_LAST)) begin
          state_d      = ST_RINGING;
          restart_ring = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      active_id  <= 2'd0;
      snooze_cnt <= 2'd0;
      sec_cnt    <= 9'd0;
      phase      <= 1'b0;
    end else begin
      state <= state_d;
      if (start_event) begin
        active_id  <= winner;
        snooze_cnt <= 2'd0;
        sec_cnt    <= 9'd0;
        phase      <= 1'b0;
      end else if (start_snooze) begin
        snooze_cnt <= snooze_cnt + 2'd1;
        sec_cnt    <= 9'd0;
      end else if (restart_ring) begin
        sec_cnt <= 9'd0;
        phase   <= 1'b0;
      end else if (sec_tick && (state != ST_IDLE)) begin
        sec_cnt <= sec_cnt + 9'd1;
        if (state == ST_RINGING) phase <= ~phase;
      end
    end
  end

  assign ring        = (state == ST_RINGING);
  assign buzzer      = ring & ~phase;
  assign alarm_armed = en;

endmodule

// File: tb/tb_alarm_unit.sv
// Directed self-checking bench for alarm_unit: time is driven directly as BCD
// words with one sec_tick per call, expectations are hand-computed.
module tb_alarm_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sec_tick = 1'b0;
  logic [19:0] hh_mm_ss = 20'd0;
  logic        am_pm = 1'b0;
  logic        mode12h = 1'b0;
  logic        set_time = 1'b0;
  logic        alarm_wr = 1'b0;
  logic [1:0]  alarm_id = 2'd0;
  logic [19:0] alarm_time = 20'd0;
  logic        alarm_am_pm = 1'b0;
  logic        alarm_en_in = 1'b0;
  logic        btn_stop = 1'b0;
  logic        btn_snooze = 1'b0;
  logic        ring, buzzer;
  logic [1:0]  active_id, snooze_cnt;
  logic [3:0]  alarm_armed;

  int total = 0;
  int bad = 0;

  alarm_unit dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick), .hh_mm_ss(hh_mm_ss),
    .am_pm(am_pm), .mode12h(mode12h), .set_time(set_time),
    .alarm_wr(alarm_wr), .alarm_id(alarm_id), .alarm_time(alarm_time),
    .alarm_am_pm(alarm_am_pm), .alarm_en_in(alarm_en_in),
    .btn_stop(btn_stop), .btn_snooze(btn_snooze),
    .ring(ring), .buzzer(buzzer), .active_id(active_id),
    .snooze_cnt(snooze_cnt), .alarm_armed(alarm_armed)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] bcd(input int h, input int m, input int s);
    bcd = {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int h, input int m, input int s, input logic pm);
    hh_mm_ss = bcd(h, m, s);
    am_pm    = pm;
    sec_tick = 1'b1;
    cycle();
    sec_tick = 1'b0;
    cycle();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick(23, 59, 1, 1'b0);
  endtask

  task automatic wr_slot(input int id, input int h, input int m, input logic pm, input logic en);
    alarm_wr    = 1'b1;
    alarm_id    = 2'(id);
    alarm_time  = bcd(h, m, 0);
    alarm_am_pm = pm;
    alarm_en_in = en;
    cycle();
    alarm_wr = 1'b0;
  endtask

  task automatic press(input logic stop, input logic snz);
    btn_stop   = stop;
    btn_snooze = snz;
    repeat (5) cycle();
    btn_stop   = 1'b0;
    btn_snooze = 1'b0;
    repeat (4) cycle();
  endtask

  initial begin
    #2;
    check("rst_ring", ring, 0);
    check("rst_buzzer", buzzer, 0);
    check("rst_active_id", active_id, 0);
    check("rst_snooze_cnt", snooze_cnt, 0);
    check("rst_armed", alarm_armed, 0);
    repeat (2) cycle();
    rst = 1'b1;
    cycle();

    // 1: 24h alarm at 07:30 in slot 2, auto-stop after 60 s
    wr_slot(2, 7, 30, 1'b0, 1'b1);
    check("t1_armed", alarm_armed, 4'b0100);
    tick(7, 29, 59, 1'b0);
    check("t1_no_early", ring, 0);
    hh_mm_ss = bcd(7, 30, 0);
    sec_tick = 1'b1;
    cycle();
    sec_tick = 1'b0;
    check("t1_ring_1clk", ring, 1);
    check("t1_active_id", active_id, 2);
    check("t1_buzz_on", buzzer, 1);
    cycle();
    tick(7, 30, 1, 1'b0);
    check("t1_buzz_off", buzzer, 0);
    ticks(58);
    check("t1_ring_59s", ring, 1);
    ticks(1);
    check("t1_autostop", ring, 0);

    // 2: 12h mode, 12:15 PM alarm in slot 0
    mode12h = 1'b1;
    wr_slot(0, 0, 15, 1'b1, 1'b1);
    tick(0, 15, 0, 1'b1);
    check("t2_pm_ring", ring, 1);
    check("t2_active_id", active_id, 0);
    press(1'b1, 1'b0);
    check("t2_stop", ring, 0);
    tick(0, 15, 0, 1'b0);
    check("t2_am_quiet", ring, 0);

    // 3: slots 1 and 3 both 06:00 -> lowest index wins
    mode12h = 1'b0;
    wr_slot(1, 6, 0, 1'b0, 1'b1);
    wr_slot(3, 6, 0, 1'b0, 1'b1);
    check("t3_armed", alarm_armed, 4'b1111);
    tick(6, 0, 0, 1'b0);
    check("t3_ring", ring, 1);
    check("t3_active_id", active_id, 1);

    // 4: three snoozes, fourth ignored, then stop
    for (int n = 1; n <= 3; n++) begin
      press(1'b0, 1'b1);
      check("t4_snooze_ring", ring, 0);
      check("t4_snooze_cnt", snooze_cnt, 32'(n));
      ticks(299);
      check("t4_still_snooze", ring, 0);
      ticks(1);
      check("t4_ring_again", ring, 1);
    end
    press(1'b0, 1'b1);
    check("t4_4th_ignored", ring, 1);
    check("t4_cnt_max", snooze_cnt, 3);
    press(1'b1, 1'b0);
    check("t4_stop", ring, 0);
    check("t4_cnt_kept", snooze_cnt, 3);

    // 5: simultaneous stop+snooze, then set_time suppresses match
    tick(6, 0, 0, 1'b0);
    check("t5_ring", ring, 1);
    check("t5_cnt_cleared", snooze_cnt, 0);
    press(1'b1, 1'b1);
    check("t5_stop_wins", ring, 0);
    check("t5_cnt_same", snooze_cnt, 0);
    set_time = 1'b1;
    tick(6, 0, 0, 1'b0);
    check("t5_set_time", ring, 0);
    set_time = 1'b0;

    // 6: asynchronous reset mid-snooze
    tick(6, 0, 0, 1'b0);
    press(1'b0, 1'b1);
    check("t6_in_snooze_cnt", snooze_cnt, 1);
    check("t6_armed_before", alarm_armed, 4'b1111);
    ticks(3);
    rst = 1'b0;
    #1;
    check("t6_async_ring", ring, 0);
    check("t6_async_armed", alarm_armed, 0);
    check("t6_async_cnt", snooze_cnt, 0);
    cycle();
    rst = 1'b1;
    cycle();
    tick(6, 0, 0, 1'b0);
    check("t6_no_ring_after", ring, 0);
    tick(7, 30, 0, 1'b0);
    check("t6_no_ring_0730", ring, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
